// File: rtl/vdp18_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp18_pkg                                                            |
// | Shared VRAM access types, sequencer states and timing constants.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vdp18_pkg;

    typedef enum logic [3:0] {
        AC_NONE,
        AC_PNT,
        AC_PGT,
        AC_CT,
        AC_STST,
        AC_SATY,
        AC_SATX,
        AC_SATN,
        AC_SATC,
        AC_SPTH,
        AC_SPTL,
        AC_CPU,
        AC_REFR
    } access_t;

    typedef enum logic [0:0] {SCAN, DONE}    scan_t;
    typedef enum logic [0:0] {F_IDLE, F_RUN} fetch_t;

    localparam logic signed [8:0] hv_first_pix_c    = -9'sd86;
    localparam logic signed [8:0] hv_sprite_start_c = -9'sd80;
    localparam logic signed [8:0] hv_fetch_end_c    = -9'sd33;
    localparam logic [2:0]        c_sub_last        = 3'd5;

    // The low pattern byte only exists for 16x16 sprites; otherwise the slot goes to the CPU.
    function automatic access_t sprite_fetch_type(input logic [2:0] sub, input logic size16);
        access_t t;
        case (sub)
            3'd0:    t = AC_SATY;
            3'd1:    t = AC_SATX;
            3'd2:    t = AC_SATN;
            3'd3:    t = AC_SATC;
            3'd4:    t = AC_SPTH;
            default: t = size16 ? AC_SPTL : AC_CPU;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vdp18_cpu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp18_cpu_arb                                                        |
// | Latches CPU VRAM requests and grants them on CPU access strobes.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vdp18_cpu_arb
    import vdp18_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    strobe,
    input  access_t access_type,
    input  logic    cpu_req,
    output logic    cpu_ack
);

    logic r_pend;

    assign cpu_ack = strobe && (access_type == AC_CPU) && r_pend;

    // A grant wins over a still-asserted request so one request yields one ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0;
        end else if (cpu_ack) begin
            r_pend <= 1'b0;
        end else if (cpu_req) begin
            r_pend <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vdp18_access_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp18_access_sched                                                   |
// | Assigns a VRAM access type to every 2-pixel slot and strobes it.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vdp18_access_sched
    import vdp18_pkg::*;
#(
    parameter int REFR_EVERY = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_5m37_i,
    input  logic signed [8:0] num_pix_i,
    input  logic signed [8:0] num_line_i,
    input  logic              vert_inc_i,
    input  logic              reg_blank_i,
    input  logic              reg_size1_i,
    input  logic              stop_sprite_i,
    input  logic              cpu_req_i,
    output logic              cpu_ack_o,
    output access_t           access_type_o,
    output logic              clk_en_acc_o
);

    scan_t   r_scan,  scan_next;
    fetch_t  r_fetch, fetch_next;
    logic [2:0] r_sub, sub_next;
    access_t r_type,  type_next;
    logic    r_acc;

    logic       w_even_tick, w_odd_tick, w_active, w_in_window, w_refr_slot;
    logic [7:0] w_slot;

    assign w_even_tick = clk_en_5m37_i && !num_pix_i[0];
    assign w_odd_tick  = clk_en_5m37_i &&  num_pix_i[0];
    assign w_active    = reg_blank_i && !num_line_i[8] && (num_line_i <= 9'sd191);
    assign w_in_window = (num_pix_i >= hv_sprite_start_c) && (num_pix_i <= hv_fetch_end_c);
    assign w_slot      = 8'($unsigned(num_pix_i - hv_first_pix_c) >> 1);
    assign w_refr_slot = (int'(w_slot) % REFR_EVERY) == 0;

    always_comb begin
        scan_next  = r_scan;
        fetch_next = r_fetch;
        sub_next   = r_sub;
        type_next  = r_type;

        if (vert_inc_i) begin
            scan_next = SCAN;
        end else if (r_acc && (r_type == AC_STST) && stop_sprite_i) begin
            scan_next = DONE;
        end

        if (r_acc && (r_fetch == F_RUN) && stop_sprite_i) begin
            fetch_next = F_IDLE;
        end
        if (w_odd_tick && (num_pix_i == hv_fetch_end_c)) begin
            fetch_next = F_IDLE;
        end

        if (w_even_tick) begin
            if (w_active && !num_pix_i[8]) begin
                case (num_pix_i[2:1])
                    2'd0:    type_next = AC_PNT;
                    2'd1:    type_next = AC_PGT;
                    2'd2:    type_next = AC_CT;
                    default: type_next = (r_scan == SCAN) ? AC_STST : AC_CPU;
                endcase
            end else if (w_active && (num_pix_i == hv_sprite_start_c)) begin
                // No sprites found on the line: skip the whole attribute fetch.
                if (stop_sprite_i) begin
                    fetch_next = F_IDLE;
                    type_next  = AC_CPU;
                end else begin
                    fetch_next = F_RUN;
                    sub_next   = 3'd0;
                    type_next  = sprite_fetch_type(3'd0, reg_size1_i);
                end
            end else if (w_active && w_in_window && (fetch_next == F_RUN)) begin
                sub_next  = (r_sub == c_sub_last) ? 3'd0 : r_sub + 3'd1;
                type_next = sprite_fetch_type(sub_next, reg_size1_i);
            end else begin
                type_next = w_refr_slot ? AC_REFR : AC_CPU;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_scan  <= SCAN;
            r_fetch <= F_IDLE;
            r_sub   <= 3'd0;
            r_type  <= AC_NONE;
            r_acc   <= 1'b0;
        end else begin
            r_scan  <= scan_next;
            r_fetch <= fetch_next;
            r_sub   <= sub_next;
            r_type  <= type_next;
            r_acc   <= w_odd_tick;
        end
    end

    assign access_type_o = r_type;
    assign clk_en_acc_o  = r_acc;

    vdp18_cpu_arb u_cpu_arb (
        .clk         (clk_i),
        .reset       (reset_i),
        .strobe      (r_acc),
        .access_type (r_type),
        .cpu_req     (cpu_req_i),
        .cpu_ack     (cpu_ack_o)
    );

endmodule
`default_nettype wire
